// File: rtl/id_issue_if.sv
// Issue-stage bundle: decoded instruction in, ID/EX register out, plus flush and backend ready.
// The master side is the surrounding pipeline; the slave side is id_issue_stage.
interface id_issue_if #(
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int CTRL_W    = 64,
  parameter int FWD_DEPTH = 2
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [XLEN-1:0]      in_pc;
  logic [CTRL_W-1:0]    in_ctrl;
  logic                 in_rs1_rd;
  logic [RF_AW-1:0]     in_rs1_addr;
  logic                 in_rs2_rd;
  logic [RF_AW-1:0]     in_rs2_addr;
  logic                 in_rd_wen;
  logic [RF_AW-1:0]     in_rd_addr;
  logic                 in_is_load;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_pc;
  logic [CTRL_W-1:0]    out_ctrl;
  logic                 out_rd_wen;
  logic [RF_AW-1:0]     out_rd_addr;
  logic                 out_is_load;
  logic [FWD_DEPTH-1:0] out_rs1_fwd;
  logic [FWD_DEPTH-1:0] out_rs2_fwd;
  logic                 load_stall;

  modport master (
    output flush, in_valid, in_pc, in_ctrl, in_rs1_rd, in_rs1_addr, in_rs2_rd, in_rs2_addr,
           in_rd_wen, in_rd_addr, in_is_load, out_ready,
    input  in_ready, out_valid, out_pc, out_ctrl, out_rd_wen, out_rd_addr, out_is_load,
           out_rs1_fwd, out_rs2_fwd, load_stall
  );

  modport slave (
    input  flush, in_valid, in_pc, in_ctrl, in_rs1_rd, in_rs1_addr, in_rs2_rd, in_rs2_addr,
           in_rd_wen, in_rd_addr, in_is_load, out_ready,
    output in_ready, out_valid, out_pc, out_ctrl, out_rd_wen, out_rd_addr, out_is_load,
           out_rs1_fwd, out_rs2_fwd, load_stall
  );
endinterface

// File: rtl/id_issue_stage.sv
// ID issue stage: ID/EX register, in-flight writer scoreboard, forward-select and load-use stall.
// Optional macro ID_STALL_CNT_EN adds a saturating load-stall counter output stall_cnt.
module id_issue_stage #(
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter int CTRL_W    = 64,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1
) (
  input  logic      clk,
  input  logic      rst,
  id_issue_if.slave bus
`ifdef ID_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);
  localparam int SB_N = FWD_DEPTH - 1;

  function automatic logic [FWD_DEPTH-1:0] youngest(input logic [FWD_DEPTH-1:0] m);
    youngest = '0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (m[i]) begin
        youngest    = '0;
        youngest[i] = 1'b1;
      end
    end
  endfunction

`ifdef ID_STALL_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction
`endif

  logic                 out_valid_q, out_valid_d;
  logic                 out_rd_wen_q, out_rd_wen_d;
  logic                 out_is_load_q, out_is_load_d;
  logic [FWD_DEPTH-1:0] out_rs1_fwd_q, out_rs1_fwd_d;
  logic [FWD_DEPTH-1:0] out_rs2_fwd_q, out_rs2_fwd_d;
  logic [XLEN-1:0]      out_pc_q;
  logic [CTRL_W-1:0]    out_ctrl_q;
  logic [RF_AW-1:0]     out_rd_addr_q;
  logic [SB_N:1]        sb_wen_q, sb_wen_d;
  logic [SB_N:1]        sb_ld_q, sb_ld_d;
  logic [RF_AW-1:0]     sb_addr_q [1:SB_N];

  logic [FWD_DEPTH-1:0] src_wen, src_ld, ld_mask;
  logic [RF_AW-1:0]     src_addr [FWD_DEPTH];
  logic [FWD_DEPTH-1:0] m1, m2, fwd1, fwd2;
  logic                 stall, ready, accept;

  // Source 0 is the ID/EX register (gated by its valid); source k is scoreboard entry k.
  always_comb begin
    src_wen[0]  = out_valid_q & out_rd_wen_q;
    src_ld[0]   = out_is_load_q;
    src_addr[0] = out_rd_addr_q;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      src_wen[k]  = sb_wen_q[k];
      src_ld[k]   = sb_ld_q[k];
      src_addr[k] = sb_addr_q[k];
    end
  end

  always_comb begin
    m1      = '0;
    m2      = '0;
    ld_mask = '0;
    for (int i = 0; i < FWD_DEPTH; i++) begin
      m1[i] = src_wen[i] && (src_addr[i] == bus.in_rs1_addr) && bus.in_rs1_rd
              && (bus.in_rs1_addr != '0);
      m2[i] = src_wen[i] && (src_addr[i] == bus.in_rs2_addr) && bus.in_rs2_rd
              && (bus.in_rs2_addr != '0);
      ld_mask[i] = src_ld[i] && (i < LOAD_LAT);
    end
    fwd1   = youngest(m1);
    fwd2   = youngest(m2);
    stall  = bus.in_valid && (|((fwd1 | fwd2) & ld_mask));
    ready  = bus.flush || (bus.out_ready && !stall);
    accept = bus.in_valid && ready && !bus.flush;
  end

  // Next state: flush kills the output slot even while the backend is stalled.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_rd_wen_d  = out_rd_wen_q;
    out_is_load_d = out_is_load_q;
    out_rs1_fwd_d = out_rs1_fwd_q;
    out_rs2_fwd_d = out_rs2_fwd_q;
    sb_wen_d      = sb_wen_q;
    sb_ld_d       = sb_ld_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (bus.out_ready) begin
      out_valid_d   = accept;
      out_rd_wen_d  = accept && bus.in_rd_wen;
      out_is_load_d = accept && bus.in_is_load;
      out_rs1_fwd_d = accept ? fwd1 : '0;
      out_rs2_fwd_d = accept ? fwd2 : '0;
    end
    if (bus.out_ready) begin
      sb_wen_d[1] = out_valid_q && out_rd_wen_q && !bus.flush;
      sb_ld_d[1]  = out_is_load_q;
      for (int k = 2; k <= SB_N; k++) begin
        sb_wen_d[k] = sb_wen_q[k-1];
        sb_ld_d[k]  = sb_ld_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_rd_wen_q  <= 1'b0;
      out_is_load_q <= 1'b0;
      out_rs1_fwd_q <= '0;
      out_rs2_fwd_q <= '0;
      sb_wen_q      <= '0;
      sb_ld_q       <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_rd_wen_q  <= out_rd_wen_d;
      out_is_load_q <= out_is_load_d;
      out_rs1_fwd_q <= out_rs1_fwd_d;
      out_rs2_fwd_q <= out_rs2_fwd_d;
      sb_wen_q      <= sb_wen_d;
      sb_ld_q       <= sb_ld_d;
    end
  end

  // Datapath fields carry no reset; they are qualified by the valid/wen bits above.
  always_ff @(posedge clk) begin
    if (bus.out_ready) begin
      sb_addr_q[1] <= out_rd_addr_q;
      for (int k = 2; k <= SB_N; k++) sb_addr_q[k] <= sb_addr_q[k-1];
    end
    if (bus.out_ready && !bus.flush) begin
      out_pc_q      <= bus.in_pc;
      out_ctrl_q    <= bus.in_ctrl;
      out_rd_addr_q <= bus.in_rd_addr;
    end
  end

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && bus.out_ready && !bus.flush) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

  assign bus.in_ready    = ready;
  assign bus.load_stall  = stall;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pc      = out_pc_q;
  assign bus.out_ctrl    = out_ctrl_q;
  assign bus.out_rd_wen  = out_rd_wen_q;
  assign bus.out_rd_addr = out_rd_addr_q;
  assign bus.out_is_load = out_is_load_q;
  assign bus.out_rs1_fwd = out_rs1_fwd_q;
  assign bus.out_rs2_fwd = out_rs2_fwd_q;
endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed hazard scenarios plus randomized traffic against a
// queue-based model of the in-flight writers.
module tb_id_issue_stage;
  localparam int FD = 2;
  localparam int LL = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  logic [31:0] pc_cnt = 32'h1000;

  always #5 clk = ~clk;

  id_issue_if #(.XLEN(32), .RF_AW(5), .CTRL_W(64), .FWD_DEPTH(FD)) bus ();

`ifdef ID_STALL_CNT_EN
  logic [31:0] stall_cnt;
  id_issue_stage #(.XLEN(32), .RF_AW(5), .CTRL_W(64), .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_cnt(stall_cnt));
`else
  id_issue_stage #(.XLEN(32), .RF_AW(5), .CTRL_W(64), .FWD_DEPTH(FD), .LOAD_LAT(LL)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {logic wen; logic [4:0] addr; logic ld;} ent_t;

  // Model: previous occupants of the output slot, youngest first.
  ent_t        older[$];
  logic        m_ov, m_wen, m_ld;
  logic [4:0]  m_rd;
  logic [31:0] m_pc;
  logic [63:0] m_ctrl;
  logic [FD-1:0] m_f1, m_f2;
  int unsigned m_cnt;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic r1rd, input logic [4:0] r1, input logic r2rd,
                     input logic [4:0] r2, input logic wen, input logic [4:0] rd, input logic ld);
    pc_cnt          += 4;
    bus.in_valid    = v;
    bus.in_pc       = pc_cnt;
    bus.in_ctrl     = {$urandom, $urandom};
    bus.in_rs1_rd   = r1rd;
    bus.in_rs1_addr = r1;
    bus.in_rs2_rd   = r2rd;
    bus.in_rs2_addr = r2;
    bus.in_rd_wen   = wen;
    bus.in_rd_addr  = rd;
    bus.in_is_load  = ld;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drv(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drv(1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1);
    tick();
    tick();
    vectors++;
    if ({bus.out_valid, bus.out_rd_wen, bus.out_is_load, bus.out_rs1_fwd, bus.out_rs2_fwd} !== '0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got v=%b wen=%b ld=%b f1=%b f2=%b required all zero",
               bus.out_valid, bus.out_rd_wen, bus.out_is_load, bus.out_rs1_fwd, bus.out_rs2_fwd);
    end
`ifdef ID_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_cnt: got %0d required 0", stall_cnt);
    end
`endif
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_alu_dep;
    logic [FD-1:0] exp_f [3];
    exp_f = '{2'b01, 2'b10, 2'b00};
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
    tick();
    for (int n = 0; n < 3; n++) begin
      drv(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd6, 1'b0);
      #1;
      vectors++;
      if (bus.load_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL alu_nostall[%0d]: got stall=%b ready=%b required 0/1", n, bus.load_stall, bus.in_ready);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_rs1_fwd !== exp_f[n]) begin
        miscompares++;
        $display("FAIL alu_fwd[%0d]: got v=%b f1=%b required 1/%b", n, bus.out_valid, bus.out_rs1_fwd, exp_f[n]);
      end
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use;
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
    tick();
    drv(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.load_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL lu_stall: got ready=%b stall=%b required 0/1", bus.in_ready, bus.load_stall);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_bubble: got out_valid=%b required 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.load_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL lu_release: got ready=%b stall=%b required 1/0", bus.in_ready, bus.load_stall);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rs2_fwd !== 2'b10 || bus.out_rd_addr !== 5'd8) begin
      miscompares++;
      $display("FAIL lu_issue: got v=%b f2=%b rd=%0d required 1/10/8", bus.out_valid, bus.out_rs2_fwd, bus.out_rd_addr);
    end
`ifdef ID_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL lu_cnt: got %0d required 1", stall_cnt);
    end
`endif
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0;
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    tick();
    drv(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b0);
    #1;
    vectors++;
    if (bus.load_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_stall: got stall=%b ready=%b required 0/1", bus.load_stall, bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_fwd !== 2'b00 || bus.out_rs2_fwd !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_fwd: got v=%b f1=%b f2=%b required 1/00/00", bus.out_valid, bus.out_rs1_fwd, bus.out_rs2_fwd);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backend_stall;
    logic [31:0] ppc, qpc;
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
    ppc = bus.in_pc;
    tick();
    drv(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, 5'd10, 1'b0);
    qpc = bus.in_pc;
    bus.out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      #1;
      vectors++;
      if (bus.in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bs_ready[%0d]: got %b required 0", n, bus.in_ready);
      end
      tick();
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== ppc || bus.out_rs1_fwd !== 2'b00) begin
        miscompares++;
        $display("FAIL bs_hold[%0d]: got v=%b pc=%h f1=%b required 1/%h/00", n, bus.out_valid, bus.out_pc, bus.out_rs1_fwd, ppc);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bs_resume_ready: got %b required 1", bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== qpc || bus.out_rs1_fwd !== 2'b01) begin
      miscompares++;
      $display("FAIL bs_resume: got v=%b pc=%h f1=%b required 1/%h/01", bus.out_valid, bus.out_pc, bus.out_rs1_fwd, qpc);
    end
    bus.in_valid = 1'b0;
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bs_nodup: got out_valid=%b required 0", bus.out_valid);
    end
  endtask

  task automatic test_flush_stall;
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
    tick();
    drv(1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fl_pre: got in_ready=%b required 0", bus.in_ready);
    end
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL fl_ready: got in_ready=%b required 1", bus.in_ready);
    end
    tick();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fl_kill: got out_valid=%b required 0", bus.out_valid);
    end
`ifdef ID_STALL_CNT_EN
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL fl_cnt: got %0d required 0", stall_cnt);
    end
`endif
    tick();
  endtask

  task automatic test_reset_midstream;
    do_reset();
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1);
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_is_load !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_load: got v=%b ld=%b required 1/1", bus.out_valid, bus.out_is_load);
    end
    rst = 1'b1;
    drv(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0);
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rm_clear: got out_valid=%b required 0", bus.out_valid);
    end
    drv(1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    #1;
    vectors++;
    if (bus.load_stall !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rm_nostall: got stall=%b ready=%b required 0/1", bus.load_stall, bus.in_ready);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_rs1_fwd !== 2'b00) begin
      miscompares++;
      $display("FAIL rm_fwd: got v=%b f1=%b required 1/00", bus.out_valid, bus.out_rs1_fwd);
    end
    bus.in_valid = 1'b0;
    tick();
  endtask

  function automatic ent_t src(input int i);
    ent_t s;
    if (i == 0) begin
      s.wen = m_ov && m_wen;
      s.addr = m_rd;
      s.ld = m_ld;
    end else begin
      s = older[i-1];
    end
    return s;
  endfunction

  function automatic int ymatch(input logic rd, input logic [4:0] a);
    ent_t s;
    if (!rd || a == 5'd0) return -1;
    for (int i = 0; i < FD; i++) begin
      s = src(i);
      if (s.wen && s.addr == a) return i;
    end
    return -1;
  endfunction

  task automatic test_random;
    int j1, j2;
    logic e_stall, e_ready, acc, fl, ordy;
    logic [FD-1:0] ef1, ef2;
    ent_t z, ns;
    do_reset();
    z.wen = 1'b0; z.addr = 5'd0; z.ld = 1'b0;
    older.delete();
    for (int k = 0; k < FD - 1; k++) older.push_back(z);
    m_ov = 1'b0; m_wen = 1'b0; m_ld = 1'b0; m_rd = 5'd0; m_pc = '0; m_ctrl = '0;
    m_f1 = '0; m_f2 = '0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      drv($urandom_range(0, 9) < 8, 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
          5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      ordy = $urandom_range(0, 3) != 0;
      fl   = $urandom_range(0, 15) == 0;
      bus.out_ready = ordy;
      bus.flush = fl;
      j1 = ymatch(bus.in_rs1_rd, bus.in_rs1_addr);
      j2 = ymatch(bus.in_rs2_rd, bus.in_rs2_addr);
      ef1 = '0; ef2 = '0;
      if (j1 >= 0) ef1[j1] = 1'b1;
      if (j2 >= 0) ef2[j2] = 1'b1;
      e_stall = bus.in_valid && ((j1 >= 0 && j1 < LL && src(j1).ld) || (j2 >= 0 && j2 < LL && src(j2).ld));
      e_ready = fl || (ordy && !e_stall);
      acc = bus.in_valid && e_ready && !fl;
      #1;
      vectors++;
      if (bus.in_ready !== e_ready || bus.load_stall !== e_stall) begin
        miscompares++;
        $display("FAIL rnd_comb[%0d]: got ready=%b stall=%b required %b/%b", n, bus.in_ready, bus.load_stall, e_ready, e_stall);
      end
      if (e_stall && ordy && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt++;
      if (ordy) begin
        ns.wen = m_ov && m_wen && !fl;
        ns.addr = m_rd;
        ns.ld = m_ld;
        older.push_front(ns);
        void'(older.pop_back());
      end
      if (fl) begin
        m_ov = 1'b0;
      end else if (ordy) begin
        m_ov = acc;
        if (acc) begin
          m_pc = bus.in_pc; m_ctrl = bus.in_ctrl; m_wen = bus.in_rd_wen; m_rd = bus.in_rd_addr;
          m_ld = bus.in_is_load; m_f1 = ef1; m_f2 = ef2;
        end
      end
      tick();
      vectors++;
      if (bus.out_valid !== m_ov) begin
        miscompares++;
        $display("FAIL rnd_valid[%0d]: got %b required %b", n, bus.out_valid, m_ov);
      end else if (m_ov) begin
        vectors++;
        if ({bus.out_pc, bus.out_ctrl, bus.out_rd_wen, bus.out_rd_addr, bus.out_is_load, bus.out_rs1_fwd, bus.out_rs2_fwd}
            !== {m_pc, m_ctrl, m_wen, m_rd, m_ld, m_f1, m_f2}) begin
          miscompares++;
          $display("FAIL rnd_out[%0d]: got pc=%h wen=%b rd=%0d ld=%b f1=%b f2=%b required pc=%h wen=%b rd=%0d ld=%b f1=%b f2=%b",
                   n, bus.out_pc, bus.out_rd_wen, bus.out_rd_addr, bus.out_is_load, bus.out_rs1_fwd, bus.out_rs2_fwd,
                   m_pc, m_wen, m_rd, m_ld, m_f1, m_f2);
        end
      end
`ifdef ID_STALL_CNT_EN
      vectors++;
      if (stall_cnt !== m_cnt) begin
        miscompares++;
        $display("FAIL rnd_cnt[%0d]: got %0d required %0d", n, stall_cnt, m_cnt);
      end
`endif
    end
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    tick();
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drv(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    test_reset();
    test_alu_dep();
    test_load_use();
    test_x0();
    test_backend_stall();
    test_flush_stall();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
